// File: rtl/spike_rate_encoder.sv
// -----------------------------------------------------------------------------
// spike_rate_encoder
//
// Front end of the spiking pipeline. A frame of N_PIX unsigned pixel
// intensities is latched on request and turned into deterministic rate-coded
// spike trains over STEPS time steps of STEP_CYCLES clocks each. Each lane runs
// a first-order accumulator seeded at half scale. The lane spikes in a step
// when adding its pixel to the accumulator overflows. Over a frame, lane i
// therefore fires round(STEPS * pix_i / 2^PIX_W) times, and never more than
// once per step.
//
// Request handshake: start is a request that is accepted only while the block
// is idle. The edge that samples start=1 in IDLE accepts the frame. That same
// edge latches pixel_in and raises busy on the following cycle. start seen
// while busy or in the one-cycle FIN state is dropped, not queued. A requester
// that holds start high gets frames back to back. The next frame is accepted
// on the first IDLE edge after done.
//
// Ports
//   clk         rising-edge clock
//   reset       asynchronous, active-low reset
//   start       frame request (sampled in IDLE only)
//   abort       synchronous frame cancel (acts in RUN only)
//   pixel_in    frame; pixel i at [i*PIX_W +: PIX_W]
//   spikes_out  spike vector for the step being presented
//   pulse       one-cycle strobe in the last cycle of every step
//   step_idx    index of the step being presented
//   busy        frame in progress
//   done        one-cycle strobe after the final step
//   dbg_state   current FSM state (IDLE=0, RUN=1, FIN=2), for observation
// All outputs come straight from flops.
// -----------------------------------------------------------------------------
module spike_rate_encoder #(
  parameter int N_PIX       = 5,
  parameter int PIX_W       = 8,
  parameter int STEPS       = 16,
  parameter int STEP_CYCLES = 4,
  localparam int SW         = (STEPS > 1) ? $clog2(STEPS) : 1,
  localparam int CW         = $clog2(STEP_CYCLES)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   abort,
  input  logic [N_PIX*PIX_W-1:0] pixel_in,
  output logic [N_PIX-1:0]       spikes_out,
  output logic                   pulse,
  output logic [SW-1:0]          step_idx,
  output logic                   busy,
  output logic                   done,
  output logic [1:0]             dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIN  = 2'd2
  } state_t;

  localparam logic [PIX_W-1:0] ACC_INIT  = {1'b1, {(PIX_W-1){1'b0}}};
  localparam logic [SW-1:0]    LAST_STEP = SW'(STEPS - 1);
  localparam logic [CW-1:0]    LAST_SUB  = CW'(STEP_CYCLES - 1);

  state_t             r_state;
  state_t             w_state_nxt;

  // r_sub == 0 marks "the next edge opens a step". That holds in the prefix
  // cycle after acceptance and in every pulse cycle. The counter then runs
  // 1..STEP_CYCLES-1 through the step and wraps to 0 on the pulse edge.
  logic [CW-1:0]      r_sub;
  logic [N_PIX-1:0]   r_spikes;
  logic               r_pulse;
  logic [SW-1:0]      r_idx;
  logic               r_busy;
  logic               r_done;
  logic [PIX_W-1:0]   r_pix [N_PIX];
  logic [PIX_W-1:0]   r_acc [N_PIX];

  logic [CW-1:0]      w_sub_nxt;
  logic [N_PIX-1:0]   w_spikes_nxt;
  logic               w_pulse_nxt;
  logic [SW-1:0]      w_idx_nxt;
  logic               w_busy_nxt;
  logic               w_done_nxt;
  logic               w_latch;
  logic               w_acc_en;
  logic [PIX_W:0]     w_sum [N_PIX];
  logic [N_PIX-1:0]   w_carry;

  // Per-lane accumulate: the carry out of acc + pix is the spike for the step.
  always_comb begin
    for (int i = 0; i < N_PIX; i++) begin
      w_sum[i]   = {1'b0, r_acc[i]} + {1'b0, r_pix[i]};
      w_carry[i] = w_sum[i][PIX_W];
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    w_state_nxt  = r_state;
    w_sub_nxt    = r_sub;
    w_spikes_nxt = r_spikes;
    w_pulse_nxt  = 1'b0;
    w_idx_nxt    = r_idx;
    w_busy_nxt   = r_busy;
    w_done_nxt   = 1'b0;
    w_latch      = 1'b0;
    w_acc_en     = 1'b0;

    case (r_state)
      S_IDLE: begin
        w_spikes_nxt = '0;
        w_idx_nxt    = '0;
        w_busy_nxt   = 1'b0;
        w_sub_nxt    = '0;
        if (start) begin
          w_state_nxt = S_RUN;
          w_latch     = 1'b1;
          w_busy_nxt  = 1'b1;
        end
      end

      S_RUN: begin
        if (abort) begin
          // Cancel takes priority over any pulse or step due this edge.
          w_state_nxt  = S_IDLE;
          w_spikes_nxt = '0;
          w_idx_nxt    = '0;
          w_busy_nxt   = 1'b0;
          w_sub_nxt    = '0;
        end else if (r_sub == '0) begin
          if (r_pulse && (r_idx == LAST_STEP)) begin
            // The final step's pulse cycle has been shown; wrap up the frame.
            w_state_nxt  = S_FIN;
            w_done_nxt   = 1'b1;
            w_busy_nxt   = 1'b0;
            w_spikes_nxt = '0;
            w_idx_nxt    = '0;
          end else begin
            // Open a step. A pulse cycle precedes every step except the first.
            w_acc_en     = 1'b1;
            w_spikes_nxt = w_carry;
            w_idx_nxt    = r_pulse ? (r_idx + SW'(1)) : r_idx;
            w_sub_nxt    = CW'(1);
          end
        end else if (r_sub == LAST_SUB) begin
          w_pulse_nxt = 1'b1;
          w_sub_nxt   = '0;
        end else begin
          w_sub_nxt = r_sub + CW'(1);
        end
      end

      S_FIN: begin
        w_state_nxt  = S_IDLE;
        w_busy_nxt   = 1'b0;
        w_spikes_nxt = '0;
        w_idx_nxt    = '0;
      end

      default: begin
        w_state_nxt  = S_IDLE;
        w_spikes_nxt = '0;
        w_idx_nxt    = '0;
        w_busy_nxt   = 1'b0;
        w_sub_nxt    = '0;
      end
    endcase
  end

  // Output and datapath registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sub    <= '0;
      r_spikes <= '0;
      r_pulse  <= 1'b0;
      r_idx    <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      for (int i = 0; i < N_PIX; i++) begin
        r_pix[i] <= '0;
        r_acc[i] <= '0;
      end
    end else begin
      r_sub    <= w_sub_nxt;
      r_spikes <= w_spikes_nxt;
      r_pulse  <= w_pulse_nxt;
      r_idx    <= w_idx_nxt;
      r_busy   <= w_busy_nxt;
      r_done   <= w_done_nxt;
      for (int i = 0; i < N_PIX; i++) begin
        if (w_latch) begin
          r_pix[i] <= pixel_in[i*PIX_W +: PIX_W];
          r_acc[i] <= ACC_INIT;
        end else if (w_acc_en) begin
          r_acc[i] <= w_sum[i][PIX_W-1:0];
        end
      end
    end
  end

  assign spikes_out = r_spikes;
  assign pulse      = r_pulse;
  assign step_idx   = r_idx;
  assign busy       = r_busy;
  assign done       = r_done;
  assign dbg_state  = r_state;

endmodule

// File: tb/tb_spike_rate_encoder.sv
// -----------------------------------------------------------------------------
// tb_spike_rate_encoder
//
// Bench for spike_rate_encoder. The reference model works from frame-level
// rules. Cycle c after acceptance belongs to step (c-1)/SC. A lane spikes in
// step s when floor(((s+1)*pix + H)/2^W) exceeds floor((s*pix + H)/2^W).
// pulse fires when c is a multiple of SC. FIN is cycle STEPS*SC+1.
// Expected per-cycle output vectors are queued in exp_q and popped as each
// cycle is sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_spike_rate_encoder;

  localparam int N_PIX     = 5;
  localparam int PIX_W     = 8;
  localparam int STEPS     = 16;
  localparam int SC        = 4;
  localparam int SW        = $clog2(STEPS);
  localparam int OW        = 3 + SW + N_PIX;
  localparam int FRAME_LEN = STEPS * SC + 2;   // cycles 0 .. STEPS*SC+1
  localparam int HALF      = 1 << (PIX_W - 1);
  localparam int FULL      = 1 << PIX_W;

  logic                   clk = 1'b0;
  logic                   reset;
  logic                   start;
  logic                   abort;
  logic [N_PIX*PIX_W-1:0] pixel_in;
  logic [N_PIX-1:0]       spikes_out;
  logic                   pulse;
  logic [SW-1:0]          step_idx;
  logic                   busy;
  logic                   done;
  logic [1:0]             dbg_state;

  int n_tests = 0;
  int n_fail  = 0;

  logic [OW-1:0] exp_q[$];
  int            pix_a [N_PIX];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #200us;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d", n_tests);
    $fatal(1, "watchdog");
  end

  spike_rate_encoder #(
    .N_PIX(N_PIX), .PIX_W(PIX_W), .STEPS(STEPS), .STEP_CYCLES(SC)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .pixel_in(pixel_in), .spikes_out(spikes_out), .pulse(pulse),
    .step_idx(step_idx), .busy(busy), .done(done), .dbg_state(dbg_state)
  );

  function automatic logic [OW-1:0] observe();
    return {busy, done, pulse, step_idx, spikes_out};
  endfunction

  // ---------------- drivers ----------------
  task automatic load_pixels();
    for (int i = 0; i < N_PIX; i++) pixel_in[i*PIX_W +: PIX_W] = PIX_W'(pix_a[i]);
  endtask

  task automatic randomize_pixels();
    for (int i = 0; i < N_PIX; i++) begin
      if ($urandom_range(0, 3) == 0) pix_a[i] = ($urandom_range(0, 1) == 1) ? FULL - 1 : 0;
      else                           pix_a[i] = int'($urandom_range(0, FULL - 1));
    end
  endtask

  // ---------------- reference model ----------------
  // Pushes cycles 0..FRAME_LEN-1 of a frame built from pix_a, plus one idle cycle.
  task automatic model_push_frame();
    for (int c = 0; c <= FRAME_LEN; c++) begin
      logic             bz, dn, pl;
      logic [SW-1:0]    ix;
      logic [N_PIX-1:0] spk;
      bz = 1'b0; dn = 1'b0; pl = 1'b0; ix = '0; spk = '0;
      if (c == 0) begin
        bz = 1'b1;
      end else if (c <= STEPS * SC) begin
        int s;
        s  = (c - 1) / SC;
        bz = 1'b1;
        pl = ((c % SC) == 0);
        ix = SW'(s);
        for (int i = 0; i < N_PIX; i++)
          spk[i] = (((s + 1) * pix_a[i] + HALF) / FULL) != ((s * pix_a[i] + HALF) / FULL);
      end else if (c == FRAME_LEN - 1) begin
        dn = 1'b1;
      end
      exp_q.push_back({bz, dn, pl, ix, spk});
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b0; start = 1'b1; abort = 1'b0; pixel_in = '1;
    repeat (3) begin
      @(negedge clk);
      n_tests++;
      if (observe() !== '0) begin
        n_fail++;
        $display("FAIL reset_hold: got %h expected %h", observe(), {OW{1'b0}});
      end
    end
    reset = 1'b1; start = 1'b0;
    repeat (2) begin
      @(negedge clk);
      n_tests++;
      if (observe() !== '0) begin
        n_fail++;
        $display("FAIL reset_idle: got %h expected %h", observe(), {OW{1'b0}});
      end
    end
  endtask

  task automatic test_frame_fixed();
    int pulses;
    int cnt    [N_PIX];
    int golden [N_PIX];
    pix_a  = '{255, 128, 16, 0, 64};
    golden = '{16, 8, 1, 0, 4};
    pulses = 0;
    for (int i = 0; i < N_PIX; i++) cnt[i] = 0;
    load_pixels();
    model_push_frame();
    start = 1'b1;
    for (int c = 0; c <= FRAME_LEN; c++) begin
      logic [OW-1:0] e;
      @(negedge clk);
      if (c == 0) start = 1'b0;
      e = exp_q.pop_front();
      n_tests++;
      if (observe() !== e) begin
        n_fail++;
        $display("FAIL frame_fixed c=%0d: got %h expected %h", c, observe(), e);
      end
      if (pulse) begin
        pulses++;
        for (int i = 0; i < N_PIX; i++) cnt[i] += int'(spikes_out[i]);
      end
    end
    n_tests++;
    if (pulses != STEPS) begin
      n_fail++;
      $display("FAIL frame_fixed_pulses: got %0d expected %0d", pulses, STEPS);
    end
    for (int i = 0; i < N_PIX; i++) begin
      n_tests++;
      if (cnt[i] != golden[i]) begin
        n_fail++;
        $display("FAIL frame_fixed_count lane%0d: got %0d expected %0d", i, cnt[i], golden[i]);
      end
    end
  endtask

  // Random frames; pixel_in is scrambled after acceptance to show only the
  // latched values matter. Frame 0 is all zeros.
  task automatic test_random_frames(input int n_frames);
    for (int f = 0; f < n_frames; f++) begin
      int pulses, total;
      pulses = 0; total = 0;
      if (f == 0) for (int i = 0; i < N_PIX; i++) pix_a[i] = 0;
      else        randomize_pixels();
      load_pixels();
      model_push_frame();
      start = 1'b1;
      for (int c = 0; c <= FRAME_LEN; c++) begin
        logic [OW-1:0] e;
        @(negedge clk);
        if (c == 0) start = 1'b0;
        e = exp_q.pop_front();
        n_tests++;
        if (observe() !== e) begin
          n_fail++;
          $display("FAIL random_frame f=%0d c=%0d: got %h expected %h", f, c, observe(), e);
        end
        if (pulse) begin
          pulses++;
          total += $countones(spikes_out);
        end
        pixel_in = (N_PIX*PIX_W)'({$urandom(), $urandom()});
      end
      if (f == 0) begin
        n_tests++;
        if (pulses != STEPS || total != 0) begin
          n_fail++;
          $display("FAIL zero_frame: got pulses=%0d spikes=%0d expected pulses=%0d spikes=0",
                   pulses, total, STEPS);
        end
      end
    end
  endtask

  task automatic test_abort();
    int pulses, dones;
    pulses = 0; dones = 0;
    pix_a = '{255, 128, 16, 0, 64};
    load_pixels();
    model_push_frame();
    // abort together with start in IDLE must not block acceptance
    start = 1'b1; abort = 1'b1;
    for (int c = 0; c <= 21; c++) begin
      logic [OW-1:0] e;
      @(negedge clk);
      if (c == 0) begin start = 1'b0; abort = 1'b0; end
      e = exp_q.pop_front();
      n_tests++;
      if (observe() !== e) begin
        n_fail++;
        $display("FAIL abort_pre c=%0d: got %h expected %h", c, observe(), e);
      end
      if (pulse) pulses++;
    end
    exp_q.delete();
    abort = 1'b1;
    for (int k = 0; k < 70; k++) begin
      @(negedge clk);
      if (k == 0) abort = 1'b0;
      if (pulse) pulses++;
      if (done)  dones++;
      n_tests++;
      if (observe() !== '0) begin
        n_fail++;
        $display("FAIL abort_post k=%0d: got %h expected %h", k, observe(), {OW{1'b0}});
      end
    end
    n_tests++;
    if (pulses != 5 || dones != 0) begin
      n_fail++;
      $display("FAIL abort_strobes: got pulses=%0d dones=%0d expected pulses=5 dones=0", pulses, dones);
    end
  endtask

  task automatic test_reset_midframe();
    pix_a = '{255, 128, 16, 0, 64};
    load_pixels();
    model_push_frame();
    start = 1'b1;
    for (int c = 0; c <= 30; c++) begin
      logic [OW-1:0] e;
      @(negedge clk);
      if (c == 0) start = 1'b0;
      e = exp_q.pop_front();
      n_tests++;
      if (observe() !== e) begin
        n_fail++;
        $display("FAIL rst_mid_pre c=%0d: got %h expected %h", c, observe(), e);
      end
    end
    exp_q.delete();
    #2 reset = 1'b0;
    #1;
    n_tests++;
    if (observe() !== '0) begin
      n_fail++;
      $display("FAIL rst_mid_async: got %h expected %h", observe(), {OW{1'b0}});
    end
    start = 1'b1;
    repeat (3) begin
      @(negedge clk);
      n_tests++;
      if (observe() !== '0) begin
        n_fail++;
        $display("FAIL rst_mid_hold: got %h expected %h", observe(), {OW{1'b0}});
      end
    end
    reset = 1'b1; start = 1'b0;
    @(negedge clk);
    n_tests++;
    if (observe() !== '0) begin
      n_fail++;
      $display("FAIL rst_mid_release: got %h expected %h", observe(), {OW{1'b0}});
    end
    randomize_pixels();
    load_pixels();
    model_push_frame();
    start = 1'b1;
    for (int c = 0; c <= FRAME_LEN; c++) begin
      logic [OW-1:0] e;
      @(negedge clk);
      if (c == 0) start = 1'b0;
      e = exp_q.pop_front();
      n_tests++;
      if (observe() !== e) begin
        n_fail++;
        $display("FAIL rst_mid_refrm c=%0d: got %h expected %h", c, observe(), e);
      end
    end
  endtask

  task automatic test_start_ignored();
    randomize_pixels();
    load_pixels();
    model_push_frame();
    start = 1'b1;
    for (int c = 0; c <= FRAME_LEN; c++) begin
      logic [OW-1:0] e;
      @(negedge clk);
      e = exp_q.pop_front();
      n_tests++;
      if (observe() !== e) begin
        n_fail++;
        $display("FAIL start_ignored c=%0d: got %h expected %h", c, observe(), e);
      end
      // start pulsed in RUN (cycle 9) and in FIN (cycle 65), dropped in IDLE
      start = (c == 9) || (c == FRAME_LEN - 1);
      if (c == 9) pixel_in = ~pixel_in;
    end
    @(negedge clk);
    n_tests++;
    if (observe() !== '0) begin
      n_fail++;
      $display("FAIL start_ignored_idle: got %h expected %h", observe(), {OW{1'b0}});
    end
  endtask

  task automatic test_back_to_back();
    randomize_pixels();
    load_pixels();
    model_push_frame();
    model_push_frame();
    start = 1'b1;
    for (int k = 0; k < 2 * (FRAME_LEN + 1); k++) begin
      logic [OW-1:0] e;
      @(negedge clk);
      e = exp_q.pop_front();
      n_tests++;
      if (observe() !== e) begin
        n_fail++;
        $display("FAIL back_to_back k=%0d: got %h expected %h", k, observe(), e);
      end
      if (k == FRAME_LEN + 1) start = 1'b0;
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_frame_fixed();
    test_random_frames(5);
    test_abort();
    test_reset_midframe();
    test_start_ignored();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
